// File: rtl/vending_pkg.sv
// vending_pkg: shared types and constants for the vending controller slice.
//   - state_e   : controller FSM states
//   - widths    : tag, item count and money field widths of the datapath
//   - CREDIT_MAX: largest credit the 4-bit money field can hold
//   - price_of  : per-tag unit price as used by the purchase-check datapath
package vending_pkg;

  localparam int unsigned TAG_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned MONEY_W    = 4;
  localparam int unsigned CREDIT_MAX = 15;

  typedef enum logic [2:0] {
    StIdle,
    StCredit,
    StCheck,
    StDispense,
    StChange
  } state_e;

  // Unit prices: tag0=1, tag1=2, tag2=3, tag3=4.
  function automatic logic [MONEY_W-1:0] price_of(input logic [TAG_W-1:0] tag);
    logic [MONEY_W-1:0] price;
    unique case (tag)
      2'd0:    price = 4'd1;
      2'd1:    price = 4'd2;
      2'd2:    price = 4'd3;
      default: price = 4'd4;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vending_stock.sv
// vending_stock: per-tag stock counters.
//   clk, reset      : clock, asynchronous active-high reset (loads the initial level)
//   chk_tag_i       : tag whose stock is being checked
//   chk_count_i     : requested quantity
//   chk_ok_o        : quantity is non-zero and no larger than the stock of chk_tag_i
//   dec_valid_i     : remove one item of dec_tag_i
//   dec_tag_i       : tag to decrement
module vending_stock
  import vending_pkg::*;
#(
  parameter int unsigned NUM_TAGS   = 4,
  parameter int unsigned MAX_STOCK  = 7,
  parameter int unsigned INIT_STOCK = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] chk_tag_i,
  input  logic [CNT_W-1:0] chk_count_i,
  output logic             chk_ok_o,
  input  logic             dec_valid_i,
  input  logic [TAG_W-1:0] dec_tag_i
);

  // Reset level is clamped to the counter ceiling.
  localparam int unsigned ResetLevel = (INIT_STOCK > MAX_STOCK) ? MAX_STOCK : INIT_STOCK;
  localparam logic [CNT_W-1:0] ResetVal = CNT_W'(ResetLevel);

  logic [CNT_W-1:0] stock_q [NUM_TAGS];
  logic [CNT_W-1:0] stock_d [NUM_TAGS];

  assign chk_ok_o = (chk_count_i != '0) && (chk_count_i <= stock_q[chk_tag_i]);

  always_comb begin
    stock_d = stock_q;
    // The controller never requests more than is in stock; the guard keeps the
    // counter from wrapping if it ever did.
    if (dec_valid_i && (stock_q[dec_tag_i] != '0)) begin
      stock_d[dec_tag_i] = stock_q[dec_tag_i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        stock_q[i] <= ResetVal;
      end
    end else begin
      stock_q <= stock_d;
    end
  end

endmodule

// File: rtl/vending_controller.sv
// vending_controller: front-end sequencer for the purchase-check datapath.
//   Coins       : coin_valid/coin_value in, coin_reject pulse out
//   Selection   : sel_valid/sel_tag/sel_count in, sel_reject pulse out, cancel in
//   Datapath    : vm_tag/vm_count/vm_money out, vm_possibility/vm_remaining in
//   Dispenser   : disp_req/disp_tag out, disp_ack in (one item per ack)
//   Change      : change_valid/change_amount out, change_ack in
//   Status      : credit, busy (high in CHECK, DISPENSE and CHANGE)
// All outputs are registered.
module vending_controller
  import vending_pkg::*;
#(
  parameter int unsigned NUM_TAGS   = 4,
  parameter int unsigned MAX_STOCK  = 7,
  parameter int unsigned INIT_STOCK = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  output logic               coin_reject,
  input  logic               sel_valid,
  input  logic [TAG_W-1:0]   sel_tag,
  input  logic [CNT_W-1:0]   sel_count,
  input  logic               cancel,
  output logic [TAG_W-1:0]   vm_tag,
  output logic [CNT_W-1:0]   vm_count,
  output logic [MONEY_W-1:0] vm_money,
  input  logic               vm_possibility,
  input  logic [MONEY_W-1:0] vm_remaining,
  output logic               disp_req,
  output logic [TAG_W-1:0]   disp_tag,
  input  logic               disp_ack,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amount,
  input  logic               change_ack,
  output logic               sel_reject,
  output logic [MONEY_W-1:0] credit,
  output logic               busy
);

  localparam logic [MONEY_W:0] CreditLimit = (MONEY_W + 1)'(CREDIT_MAX);

  state_e             state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MONEY_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]   items_left_q, items_left_d;
  logic               coin_reject_q, coin_reject_d;
  logic               sel_reject_q, sel_reject_d;
  logic [TAG_W-1:0]   vm_tag_q, vm_tag_d;
  logic [CNT_W-1:0]   vm_count_q, vm_count_d;
  logic [MONEY_W-1:0] vm_money_q, vm_money_d;
  logic               disp_req_q, disp_req_d;
  logic [TAG_W-1:0]   disp_tag_q, disp_tag_d;
  logic               change_valid_q, change_valid_d;
  logic [MONEY_W-1:0] change_amount_q, change_amount_d;
  logic               busy_q, busy_d;

  logic [MONEY_W:0]   coin_sum;
  logic               stock_ok;
  logic               stock_dec;

  vending_stock #(
    .NUM_TAGS   (NUM_TAGS),
    .MAX_STOCK  (MAX_STOCK),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk         (clk),
    .reset       (reset),
    .chk_tag_i   (sel_tag),
    .chk_count_i (sel_count),
    .chk_ok_o    (stock_ok),
    .dec_valid_i (stock_dec),
    .dec_tag_i   (tag_q)
  );

  // One bit wider than credit so an overflowing coin is detectable.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    tag_d           = tag_q;
    count_d         = count_q;
    remaining_d     = remaining_q;
    items_left_d    = items_left_q;
    coin_reject_d   = 1'b0;
    sel_reject_d    = 1'b0;
    vm_tag_d        = '0;
    vm_count_d      = '0;
    vm_money_d      = '0;
    disp_req_d      = disp_req_q;
    disp_tag_d      = disp_tag_q;
    change_valid_d  = change_valid_q;
    change_amount_d = change_amount_q;
    stock_dec       = 1'b0;

    unique case (state_q)
      StIdle, StCredit: begin
        if (cancel) begin
          // Cancel overrides any coin or selection in the same cycle.
          if (credit_q != '0) begin
            state_d         = StChange;
            change_valid_d  = 1'b1;
            change_amount_d = credit_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (coin_valid) begin
            if (coin_sum <= CreditLimit) begin
              credit_d = coin_sum[MONEY_W-1:0];
              state_d  = StCredit;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
          if (sel_valid) begin
            tag_d   = sel_tag;
            count_d = sel_count;
            if (stock_ok) begin
              // credit_d already includes a coin accepted in this same cycle.
              state_d    = StCheck;
              vm_tag_d   = sel_tag;
              vm_count_d = sel_count;
              vm_money_d = credit_d;
            end else begin
              sel_reject_d = 1'b1;
            end
          end
        end
      end

      StCheck: begin
        if (vm_possibility) begin
          remaining_d  = vm_remaining;
          items_left_d = count_q;
          state_d      = StDispense;
          disp_req_d   = 1'b1;
          disp_tag_d   = tag_q;
        end else begin
          sel_reject_d = 1'b1;
          state_d      = StCredit;
        end
      end

      StDispense: begin
        if (disp_ack) begin
          stock_dec    = 1'b1;
          items_left_d = items_left_q - CNT_W'(1);
          if (items_left_q == CNT_W'(1)) begin
            disp_req_d = 1'b0;
            disp_tag_d = '0;
            if (remaining_q != '0) begin
              // Credit now reflects only what is still owed.
              state_d         = StChange;
              credit_d        = remaining_q;
              change_valid_d  = 1'b1;
              change_amount_d = remaining_q;
            end else begin
              state_d  = StIdle;
              credit_d = '0;
            end
          end
        end
      end

      StChange: begin
        if (change_ack) begin
          state_d         = StIdle;
          credit_d        = '0;
          change_valid_d  = 1'b0;
          change_amount_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase

    // Coins offered while a transaction is in flight are turned away.
    if (busy_q && coin_valid) begin
      coin_reject_d = 1'b1;
    end

    busy_d = (state_d == StCheck) || (state_d == StDispense) || (state_d == StChange);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      credit_q        <= '0;
      tag_q           <= '0;
      count_q         <= '0;
      remaining_q     <= '0;
      items_left_q    <= '0;
      coin_reject_q   <= 1'b0;
      sel_reject_q    <= 1'b0;
      vm_tag_q        <= '0;
      vm_count_q      <= '0;
      vm_money_q      <= '0;
      disp_req_q      <= 1'b0;
      disp_tag_q      <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      tag_q           <= tag_d;
      count_q         <= count_d;
      remaining_q     <= remaining_d;
      items_left_q    <= items_left_d;
      coin_reject_q   <= coin_reject_d;
      sel_reject_q    <= sel_reject_d;
      vm_tag_q        <= vm_tag_d;
      vm_count_q      <= vm_count_d;
      vm_money_q      <= vm_money_d;
      disp_req_q      <= disp_req_d;
      disp_tag_q      <= disp_tag_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      busy_q          <= busy_d;
    end
  end

  assign coin_reject   = coin_reject_q;
  assign sel_reject    = sel_reject_q;
  assign vm_tag        = vm_tag_q;
  assign vm_count      = vm_count_q;
  assign vm_money      = vm_money_q;
  assign disp_req      = disp_req_q;
  assign disp_tag      = disp_tag_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign credit        = credit_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: coin/selection vector table, directed corner
// sequences, then random transactions against a transaction-level model.
module tb_vending_controller;

  logic       clk, reset;
  logic       coin_valid, coin_reject, sel_valid, cancel, sel_reject, busy;
  logic [3:0] coin_value, vm_money, vm_remaining, change_amount, credit;
  logic [1:0] sel_tag, vm_tag, disp_tag;
  logic [2:0] sel_count, vm_count;
  logic       vm_possibility, disp_req, disp_ack, change_valid, change_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int m_credit;
  int m_stock [4];
  int dp_cost;

  vending_controller #(
    .NUM_TAGS   (4),
    .MAX_STOCK  (7),
    .INIT_STOCK (7)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .coin_reject    (coin_reject),
    .sel_valid      (sel_valid),
    .sel_tag        (sel_tag),
    .sel_count      (sel_count),
    .cancel         (cancel),
    .vm_tag         (vm_tag),
    .vm_count       (vm_count),
    .vm_money       (vm_money),
    .vm_possibility (vm_possibility),
    .vm_remaining   (vm_remaining),
    .disp_req       (disp_req),
    .disp_tag       (disp_tag),
    .disp_ack       (disp_ack),
    .change_valid   (change_valid),
    .change_amount  (change_amount),
    .change_ack     (change_ack),
    .sel_reject     (sel_reject),
    .credit         (credit),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int price(input int tag);
    return tag + 1;
  endfunction

  // Behavioural purchase-check datapath.
  always_comb begin
    dp_cost        = price(int'(vm_tag)) * int'(vm_count);
    vm_possibility = (dp_cost <= int'(vm_money));
    vm_remaining   = vm_possibility ? 4'(int'(vm_money) - dp_cost) : vm_money;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_credit = 0;
    foreach (m_stock[i]) m_stock[i] = 7;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_stock(input string nm);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_stock%0d", nm, i), int'(dut.u_stock.stock_q[i]), m_stock[i]);
    end
  endtask

  task automatic coin(input int v);
    bit rej;
    rej = (m_credit + v) > 15;
    coin_valid = 1'b1;
    coin_value = 4'(v);
    tick();
    coin_valid = 1'b0;
    chk("coin_reject", coin_reject, rej);
    if (!rej) m_credit += v;
    chk("coin_credit", credit, m_credit);
  endtask

  task automatic take_change(input int amt);
    int d;
    d = $urandom_range(0, 2);
    chk("change_valid", change_valid, 1);
    chk("change_amount", change_amount, amt);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("change_hold", change_valid, 1);
      chk("change_stable", change_amount, amt);
    end
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    chk("change_done", change_valid, 0);
    chk("credit_after_change", credit, 0);
    chk("busy_after_change", busy, 0);
    m_credit = 0;
  endtask

  // Entered just after the edge that accepted a selection (DUT in CHECK).
  task automatic finish_purchase(input int tag, input int cnt);
    int cost;
    int served;
    int guard;
    cost   = price(tag) * cnt;
    served = 0;
    guard  = 0;
    chk("check_busy", busy, 1);
    chk("vm_tag", vm_tag, tag);
    chk("vm_count", vm_count, cnt);
    chk("vm_money", vm_money, m_credit);
    tick();
    if (cost > m_credit) begin
      chk("afford_reject", sel_reject, 1);
      chk("afford_busy", busy, 0);
      chk("afford_credit", credit, m_credit);
      return;
    end
    chk("afford_no_reject", sel_reject, 0);
    while (disp_req && guard < 40) begin
      chk("disp_tag", disp_tag, tag);
      if ($urandom_range(0, 2) == 0) begin
        coin_valid = 1'b1;
        coin_value = 4'd1;
        tick();
        coin_valid = 1'b0;
        chk("busy_coin_reject", coin_reject, 1);
        chk("disp_hold", disp_req, 1);
      end
      disp_ack = 1'b1;
      tick();
      disp_ack = 1'b0;
      served++;
      guard++;
    end
    chk("items_served", served, cnt);
    m_stock[tag] -= cnt;
    if (m_credit - cost > 0) begin
      take_change(m_credit - cost);
    end else begin
      chk("no_change", change_valid, 0);
      chk("exact_credit", credit, 0);
      chk("exact_busy", busy, 0);
      m_credit = 0;
    end
  endtask

  task automatic purchase(input int tag, input int cnt);
    bit ok;
    ok = (cnt != 0) && (cnt <= m_stock[tag]);
    sel_valid = 1'b1;
    sel_tag   = 2'(tag);
    sel_count = 3'(cnt);
    tick();
    sel_valid = 1'b0;
    if (!ok) begin
      chk("stock_reject", sel_reject, 1);
      chk("stock_reject_busy", busy, 0);
      chk("stock_reject_credit", credit, m_credit);
      return;
    end
    chk("sel_accept", sel_reject, 0);
    finish_purchase(tag, cnt);
  endtask

  task automatic cancel_op();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    if (m_credit > 0) begin
      take_change(m_credit);
    end else begin
      chk("cancel_empty_valid", change_valid, 0);
      chk("cancel_empty_busy", busy, 0);
    end
  endtask

  typedef struct {
    logic       cv;
    logic [3:0] cval;
    logic       sv;
    logic [1:0] stag;
    logic [2:0] scnt;
    logic       cn;
    logic       e_crej;
    logic       e_srej;
    logic [3:0] e_credit;
    logic       e_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_tag = '0; sel_count = '0;
    cancel = 1'b0; disp_ack = 1'b0; change_ack = 1'b0;
    reset = 1'b1;
    model_reset();
    tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp_req", disp_req, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_vm_money", vm_money, 0);
    check_stock("rst");
    reset = 1'b0;

    // Coin accumulation, overflow, zero-count selection, cancel precedence.
    vecs[0] = '{1'b1, 4'd3, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd3,  1'b0};
    vecs[1] = '{1'b1, 4'd7, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0};
    vecs[2] = '{1'b1, 4'd6, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0};
    vecs[4] = '{1'b1, 4'd5, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
    vecs[5] = '{1'b1, 4'd1, 1'b1, 2'd3, 3'd0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0};
    vecs[6] = '{1'b1, 4'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
    vecs[7] = '{1'b1, 4'd2, 1'b1, 2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1};
    for (int i = 0; i < 8; i++) begin
      coin_valid = vecs[i].cv;  coin_value = vecs[i].cval;
      sel_valid  = vecs[i].sv;  sel_tag    = vecs[i].stag; sel_count = vecs[i].scnt;
      cancel     = vecs[i].cn;
      tick();
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
      chk($sformatf("vec%0d_coin_reject", i), coin_reject, vecs[i].e_crej);
      chk($sformatf("vec%0d_sel_reject", i), sel_reject, vecs[i].e_srej);
      chk($sformatf("vec%0d_credit", i), credit, vecs[i].e_credit);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end
    m_credit = 15;
    take_change(15);

    // Exact purchase: 5+3, two items of tag 3, no change.
    apply_reset();
    coin(5); coin(3);
    purchase(3, 2);
    check_stock("exact");

    // Purchase with change: 10, three of tag 1, change 4.
    coin(10);
    purchase(1, 3);
    check_stock("change");

    // Insufficient credit, then cancel refunds 5.
    coin(5);
    purchase(2, 2);
    chk("insufficient_busy", busy, 0);
    cancel_op();

    // Overflow and zero-count selection.
    coin(12); coin(5); purchase(1, 0); cancel_op();

    // Sold out.
    apply_reset();
    coin(7); purchase(0, 7);
    check_stock("soldout");
    coin(5); purchase(0, 1); cancel_op();

    // Cancel beats a simultaneous coin.
    coin(3);
    cancel = 1'b1; coin_valid = 1'b1; coin_value = 4'd2;
    tick();
    cancel = 1'b0; coin_valid = 1'b0;
    chk("cancel_coin_reject", coin_reject, 0);
    take_change(3);

    // Coin and selection together: check sees the updated credit.
    coin(2);
    coin_valid = 1'b1; coin_value = 4'd4;
    sel_valid = 1'b1; sel_tag = 2'd1; sel_count = 3'd3;
    tick();
    coin_valid = 1'b0; sel_valid = 1'b0;
    m_credit += 4;
    chk("simul_credit", credit, 6);
    chk("simul_sel_reject", sel_reject, 0);
    finish_purchase(1, 3);

    // Reset after one of three acknowledgements.
    apply_reset();
    coin(15);
    sel_valid = 1'b1; sel_tag = 2'd2; sel_count = 3'd3;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("mid_disp_req", disp_req, 1);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    chk("mid_disp_req_after_ack", disp_req, 1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_disp_req", disp_req, 0);
    chk("async_credit", credit, 0);
    chk("async_busy", busy, 0);
    chk("async_change_valid", change_valid, 0);
    check_stock("async");
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_change_valid", change_valid, 0);

    // Random transactions.
    apply_reset();
    for (int it = 0; it < 300; it++) begin
      int r;
      if (it % 75 == 74) begin
        apply_reset();
        check_stock("rand_rst");
      end
      r = $urandom_range(0, 9);
      if (r == 0)      coin($urandom_range(0, 15));
      else if (r < 5)  coin($urandom_range(1, 5));
      else if (r < 9)  purchase($urandom_range(0, 3), $urandom_range(0, 4));
      else             cancel_op();
    end
    check_stock("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Sequential front-end controller for the combinational Vending_Machine purchase-check datapath.
- Accumulates inserted coins into a credit register and latches a product selection (tag, count).
- Drives the datapath for one check, then sequences per-item dispensing and the change return over handshakes.
- Tracks per-tag stock so sold-out requests are rejected before the datapath is consulted.

Parameters:
- NUM_TAGS, 4, number of product tags; fixed by the 2-bit Tag field.
- MAX_STOCK, 7, stock-counter ceiling; fits the 3-bit count field.
- INIT_STOCK, 7, per-tag stock value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle coin insertion strobe
- coin_value  in  4  value of the inserted coin
- coin_reject  out  1  one-cycle pulse: coin refused because credit would exceed 15
- sel_valid  in  1  selection strobe
- sel_tag  in  2  selected product tag
- sel_count  in  3  requested quantity
- cancel  in  1  abort; refund the full credit
- vm_tag  out  2  to datapath Tag
- vm_count  out  3  to datapath count
- vm_money  out  4  to datapath money (current credit)
- vm_possibility  in  1  from datapath: purchase affordable
- vm_remaining  in  4  from datapath: money minus cost
- disp_req  out  1  dispense-one-item request, held high until acknowledged
- disp_tag  out  2  tag being dispensed
- disp_ack  in  1  dispenser accepted one item
- change_valid  out  1  change offer, held high until acknowledged
- change_amount  out  4  change value
- change_ack  in  1  change taken
- sel_reject  out  1  one-cycle pulse: selection refused
- credit  out  4  current credit
- busy  out  1  high in every state except IDLE and CREDIT

Behaviour:
- Reset (async, takes effect immediately)
  - State goes to IDLE.
  - credit=0, all outputs 0, vm_* = 0.
  - Every stock counter is set to INIT_STOCK.
  - Reset in mid-transaction drops the transaction; no change is paid.
- States and transitions: IDLE, CREDIT, CHECK, DISPENSE, CHANGE.
- IDLE / CREDIT, coin_valid:
  - If credit+coin_value ≤ 15: credit += coin_value on the next edge, and state becomes CREDIT.
  - Otherwise: coin_reject pulses and credit is unchanged.
- sel_valid in IDLE/CREDIT:
  - Latch sel_tag and sel_count.
  - If sel_count==0 or sel_count > stock[sel_tag]: sel_reject pulses and the state stays put.
  - Otherwise go to CHECK.
- Simultaneous events in IDLE/CREDIT:
  - coin_valid and sel_valid together: the coin is added first; the check uses the updated credit one cycle later.
  - cancel wins over coin and selection. With credit>0, go to CHANGE with change_amount=credit; with credit==0, stay in IDLE.
- CHECK (exactly 1 cycle)
  - vm_tag, vm_count and vm_money are driven from the latched values.
  - vm_possibility and vm_remaining are sampled at the end of the cycle.
  - possibility=1: register remaining and set items_left=count, then go to DISPENSE.
  - possibility=0: sel_reject pulses and the state returns to CREDIT with credit kept.
- DISPENSE
  - disp_req=1 with disp_tag = latched tag.
  - On each cycle with disp_ack=1: stock[tag]-=1 and items_left-=1.
  - When items_left reaches 0, disp_req drops in the following cycle.
  - The next state is then CHANGE if remaining>0; otherwise IDLE with credit=0.
- CHANGE
  - change_valid=1 and change_amount is stable.
  - On change_ack: credit=0 and the state goes to IDLE.
- Inputs ignored while busy: coin_valid, sel_valid, cancel. A coin arriving while busy pulses coin_reject.
- Stock arithmetic
  - Stock never underflows, because the count ≤ stock check is done before CHECK.
  - There is no restock port; stock is restored only by reset.
- Datapath contract (for the bench model)
  - cost = PRICE[tag]*count.
  - possibility = (cost ≤ money).
  - remaining = money-cost when possible, else money.

Decomposition:
- Package vending_pkg:
  - state enum.
  - PRICE table: tag0=1, tag1=2, tag2=3, tag3=4.
  - CREDIT_MAX=15.
  - Widths TAG_W=2, CNT_W=3, MONEY_W=4.
- One natural sub-module: vending_stock, the per-tag stock counter array with check and decrement ports.

Test Plan:
- Exact purchase: coins 5 then 3 (credit 8), select tag=3 count=2 → CHECK sees possibility=1, remaining=0 → exactly two disp_req/ack items of tag 3 → back to IDLE, no change_valid, stock[3]=5.
- Purchase with change: coin 10, select tag=1 count=3 → 3 items dispensed → change_valid with change_amount=4 until ack → credit=0.
- Insufficient credit: credit 5, select tag=2 count=2 → sel_reject pulse; state is CREDIT and credit still 5; cancel → change_amount=5.
- Credit overflow: credit 12 + coin 5 → coin_reject pulse, credit stays 12. Zero-count selection → sel_reject pulse.
- Sold out: buy tag 0 count=7 with credit 7 → stock[0]=0. Next tag 0 count=1 with credit 5 → sel_reject pulse, no CHECK.
- Reset mid-dispense: assert reset after 1 of 3 acks → outputs clear immediately, credit=0, all stock=7.
